e_muldiv: RTL and testbench



---
 rtl/e_muldiv.sv | 226 ++++++++++++++++++++++
 tb/tb_e_muldiv.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/e_muldiv.sv
// Multi-cycle integer multiply/divide unit: MUL/MULH/MULHU and restoring radix-2 DIV/MOD.
// Optional macro E_MULDIV_DIV_EARLY_EXIT_EN skips the iteration for trivial/special divides.
module e_muldiv #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] r0_i,
    input  logic [WIDTH-1:0] r1_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int unsigned CNT_MAX = (WIDTH + 1 > MUL_LAT) ? WIDTH + 1 : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               div0_q, div0_d;
    logic               early_q, early_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic               accept_c;
    logic               in_sgn_c, s0_c, s1_c;
    logic [WIDTH-1:0]   abs0_c, abs1_c;
    logic               div0_in_c, ovf_in_c, early_in_c;
    logic               msgn_c;
    logic [2*WIDTH-1:0] a_ext_c, b_ext_c, prod_c;
    logic [WIDTH-1:0]   mul_res_c;
    logic [WIDTH:0]     shifted_c, diff_c;
    logic [WIDTH-1:0]   q_fix_c, r_fix_c, div_res_c;

    assign in_ready_o  = (state_q == S_IDLE) && !rst;
    assign accept_c    = in_valid_i && (state_q == S_IDLE) && !flush_i;
    assign out_valid_o = valid_q;
    assign result_o    = result_q;
    assign tag_o       = tag_q;

    // Operand pre-processing for divides: magnitudes, sign flags, special cases
    always_comb begin
        in_sgn_c  = op_i[2] && !op_i[1];
        s0_c      = in_sgn_c && r0_i[WIDTH-1];
        s1_c      = in_sgn_c && r1_i[WIDTH-1];
        abs0_c    = s0_c ? (~r0_i + WIDTH'(1)) : r0_i;
        abs1_c    = s1_c ? (~r1_i + WIDTH'(1)) : r1_i;
        div0_in_c = (r1_i == '0);
        ovf_in_c  = in_sgn_c && (r0_i == MIN_V) && (r1_i == '1);
`ifdef E_MULDIV_DIV_EARLY_EXIT_EN
        early_in_c = op_i[2] && (div0_in_c || ovf_in_c || (abs0_c < abs1_c));
`else
        early_in_c = 1'b0;
`endif
    end

    // Full-width product; MULH sign-extends both operands, the others zero-extend
    always_comb begin
        msgn_c    = (op_q == 3'b001);
        a_ext_c   = {{WIDTH{msgn_c & a_q[WIDTH-1]}}, a_q};
        b_ext_c   = {{WIDTH{msgn_c & b_q[WIDTH-1]}}, b_q};
        prod_c    = a_ext_c * b_ext_c;
        case (op_q[1:0])
            2'b00:   mul_res_c = prod_c[WIDTH-1:0];
            2'b11:   mul_res_c = '0;
            default: mul_res_c = prod_c[2*WIDTH-1:WIDTH];
        endcase
    end

    // Restoring divide step and final sign fix-up
    always_comb begin
        shifted_c = {rem_q, a_q[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, b_q};
        q_fix_c   = negq_q ? (~a_q + WIDTH'(1)) : a_q;
        if (div0_q) begin
            q_fix_c = '1;
        end
        r_fix_c   = negr_q ? (~rem_q + WIDTH'(1)) : rem_q;
        div_res_c = op_q[0] ? r_fix_c : q_fix_c;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        div0_d   = div0_q;
        early_d  = early_q;
        result_d = result_q;
        valid_d  = valid_q;
        tag_d    = tag_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    op_d    = op_i;
                    tag_d   = tag_i;
                    cnt_d   = '0;
                    early_d = early_in_c;
                    div0_d  = op_i[2] && div0_in_c;
                    negq_d  = s0_c ^ s1_c;
                    negr_d  = s0_c;
                    if (op_i[2]) begin
                        state_d = S_DIV;
                        b_d     = abs1_c;
                        a_d     = abs0_c;
                        rem_d   = '0;
                        if (early_in_c) begin
                            // Skip iterations: one spacer cycle, then fix-up
                            cnt_d = CNT_W'(WIDTH - 1);
                            if (div0_in_c) begin
                                a_d   = '0;
                                rem_d = abs0_c;
                            end else if (ovf_in_c) begin
                                a_d   = MIN_V;
                                rem_d = '0;
                            end else begin
                                a_d   = '0;
                                rem_d = abs0_c;
                            end
                        end
                    end else begin
                        state_d = S_MUL;
                        a_d     = r0_i;
                        b_d     = r1_i;
                    end
                end
            end
            S_MUL: begin
                if ((op_q[1:0] == 2'b11) || (cnt_q == CNT_W'(MUL_LAT - 1))) begin
                    result_d = mul_res_c;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DIV: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    result_d = div_res_c;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!early_q) begin
                        if (!diff_c[WIDTH]) begin
                            rem_d = diff_c[WIDTH-1:0];
                            a_d   = {a_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = shifted_c[WIDTH-1:0];
                            a_d   = {a_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush discards any in-flight or held result
        if (flush_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            div0_q   <= 1'b0;
            early_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            div0_q   <= div0_d;
            early_q  <= early_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
        end
    end

endmodule

// File: tb/tb_e_muldiv.sv
// Directed bench for e_muldiv (WIDTH=32, TAG_W=6, MUL_LAT=2); honours E_MULDIV_DIV_EARLY_EXIT_EN.
module tb_e_muldiv;

    localparam int DL = 33;
`ifdef E_MULDIV_DIV_EARLY_EXIT_EN
    localparam int EL = 2;
`else
    localparam int EL = 33;
`endif

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  op_i;
    logic [31:0] r0_i;
    logic [31:0] r1_i;
    logic [5:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [5:0]  tag_o;

    int n_vec;
    int n_bad;

    e_muldiv #(.WIDTH(32), .TAG_W(6), .MUL_LAT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .op_i       (op_i),
        .r0_i       (r0_i),
        .r1_i       (r1_i),
        .tag_i      (tag_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .result_o   (result_o),
        .tag_o      (tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for ready, then present one request across its accept edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tg, input string name);
        int guard;
        guard = 0;
        while (!in_ready_o && guard < 200) begin
            tick();
            guard++;
        end
        check({name, ".ready"}, 32'(in_ready_o), 32'd1);
        op_i       = op;
        r0_i       = a;
        r1_i       = b;
        tag_i      = tg;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        r0_i       = $urandom;
        r1_i       = $urandom;
        tag_i      = 6'($urandom);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tg, input logic [31:0] exp, input int exp_lat,
                          input string name);
        int lat;
        issue(op, a, b, tg, name);
        lat = 0;
        while (!out_valid_o && lat < 100) begin
            tick();
            lat++;
        end
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".res"}, result_o, exp);
        check({name, ".tag"}, 32'(tag_o), 32'(tg));
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({name, ".vld_drop"}, 32'(out_valid_o), 32'd0);
        check({name, ".rdy_back"}, 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        int seen;
        n_vec       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        op_i        = '0;
        r0_i        = '0;
        r1_i        = '0;
        tag_i       = '0;

        repeat (3) tick();
        check("rst.ready", 32'(in_ready_o), 32'd0);
        check("rst.valid", 32'(out_valid_o), 32'd0);
        check("rst.result", result_o, 32'd0);
        check("rst.tag", 32'(tag_o), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.ready_after", 32'(in_ready_o), 32'd1);

        // Multiplies and reserved op
        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 6'd5,  32'hFFFFFFEB, 2, "mul_7x-3");
        run_op(3'b001, 32'h80000000, 32'h80000000, 6'd6,  32'h40000000, 2, "mulh_min");
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd7,  32'hFFFFFFFE, 2, "mulhu_max");
        run_op(3'b001, 32'hFFFFFFFF, 32'd2,        6'd8,  32'hFFFFFFFF, 2, "mulh_-1x2");
        run_op(3'b010, 32'hFFFFFFFF, 32'd2,        6'd9,  32'h00000001, 2, "mulhu_x2");
        run_op(3'b011, 32'd123,      32'd456,      6'd10, 32'h00000000, 1, "reserved");

        // Divides
        run_op(3'b110, 32'd100,      32'd7,        6'd11, 32'd14,       DL, "divu_100_7");
        run_op(3'b111, 32'd100,      32'd7,        6'd12, 32'd2,        DL, "modu_100_7");
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        6'd13, 32'hFFFFFFFD, DL, "div_-7_2");
        run_op(3'b101, 32'hFFFFFFF9, 32'd2,        6'd14, 32'hFFFFFFFF, DL, "mod_-7_2");
        run_op(3'b100, 32'd7,        32'hFFFFFFFE, 6'd15, 32'hFFFFFFFD, DL, "div_7_-2");
        run_op(3'b101, 32'd7,        32'hFFFFFFFE, 6'd16, 32'd1,        DL, "mod_7_-2");
        run_op(3'b110, 32'd7,        32'd7,        6'd17, 32'd1,        DL, "divu_eq");
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 6'd18, 32'h80000000, EL, "div_ovf");
        run_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 6'd19, 32'd0,        EL, "mod_ovf");
        run_op(3'b110, 32'd5,        32'd0,        6'd20, 32'hFFFFFFFF, EL, "divu_by0");
        run_op(3'b111, 32'd5,        32'd0,        6'd21, 32'd5,        EL, "modu_by0");
        run_op(3'b100, 32'hFFFFFFFB, 32'd0,        6'd22, 32'hFFFFFFFF, EL, "div_-5_by0");
        run_op(3'b101, 32'hFFFFFFFB, 32'd0,        6'd23, 32'hFFFFFFFB, EL, "mod_-5_by0");
        run_op(3'b110, 32'd3,        32'd10,       6'd24, 32'd0,        EL, "divu_small");
        run_op(3'b101, 32'hFFFFFFFD, 32'd10,       6'd25, 32'hFFFFFFFD, EL, "mod_-3_10");
        run_op(3'b100, 32'hFFFFFFFD, 32'd10,       6'd26, 32'd0,        EL, "div_-3_10");

        // Back-pressure: result held while consumer stalls
        issue(3'b000, 32'h1234, 32'h10, 6'd9, "hold");
        seen = 0;
        while (!out_valid_o && seen < 100) begin
            tick();
            seen++;
        end
        check("hold.lat", 32'(seen), 32'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold.res", result_o, 32'h00012340);
            check("hold.tag", 32'(tag_o), 32'd9);
            check("hold.valid", 32'(out_valid_o), 32'd1);
            check("hold.ready", 32'(in_ready_o), 32'd0);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("hold.release_valid", 32'(out_valid_o), 32'd0);
        check("hold.release_ready", 32'(in_ready_o), 32'd1);

        // Flush ten cycles into a divide
        issue(3'b110, 32'd1000, 32'd3, 6'd30, "flush");
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush.ready", 32'(in_ready_o), 32'd1);
        check("flush.valid", 32'(out_valid_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid_o) seen++;
        end
        check("flush.no_valid", 32'(seen), 32'd0);
        run_op(3'b000, 32'd3, 32'd4, 6'd31, 32'd12, 2, "flush.mul");

        // Reset pulsed mid-divide
        issue(3'b110, 32'd1000, 32'd3, 6'd32, "rstmid");
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("rstmid.ready_in_rst", 32'(in_ready_o), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rstmid.ready", 32'(in_ready_o), 32'd1);
        check("rstmid.valid", 32'(out_valid_o), 32'd0);
        check("rstmid.result", result_o, 32'd0);
        check("rstmid.tag", 32'(tag_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid_o) seen++;
        end
        check("rstmid.no_valid", 32'(seen), 32'd0);
        run_op(3'b000, 32'd3, 32'd4, 6'd33, 32'd12, 2, "rstmid.mul");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
